// File: rtl/rr_mux_arbiter_4.sv
// rtl/rr_mux_arbiter_4.sv - round-robin 4:1 valid/ready mux with a registered output slot
// Optional ARB_BURST_EN: the current winner keeps priority for up to MAX_BURST consecutive transfers.
module rr_mux_arbiter_4 #(
  parameter int W         = 4,
  parameter int MAX_BURST = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   in_valid,
  input  logic [W-1:0] in_data0,
  input  logic [W-1:0] in_data1,
  input  logic [W-1:0] in_data2,
  input  logic [W-1:0] in_data3,
  output logic [3:0]   in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   out_id
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t       state, state_nxt;
  logic [1:0]   ptr, ptr_nxt;
  logic [1:0]   win;
  logic         found;
  logic         space;
  logic         xfer;
  logic [W-1:0] sel_data;

  assign out_valid = (state == FULL);
  assign space     = (state == EMPTY) || out_ready;

  // First valid requester scanning upward from ptr, wrapping modulo 4.
  always_comb begin
    win   = ptr;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!found && in_valid[ptr + 2'(k)]) begin
        found = 1'b1;
        win   = ptr + 2'(k);
      end
    end
  end

  assign in_ready = (!rst && space && found) ? (4'b0001 << win) : 4'b0000;
  assign xfer     = |in_ready;

  assign sel_data = (win == 2'd3) ? in_data3 :
                    (win == 2'd2) ? in_data2 :
                    (win == 2'd1) ? in_data1 : in_data0;

`ifdef ARB_BURST_EN
  logic [3:0] bcnt, bcnt_nxt;
  logic [4:0] run;

  // out_id doubles as the last winner; a new winner starts its own burst at 1.
  always_comb begin
    ptr_nxt  = ptr;
    bcnt_nxt = bcnt;
    run      = (win == out_id) ? ({1'b0, bcnt} + 5'd1) : 5'd1;
    if (xfer) begin
      if (32'(run) < MAX_BURST) begin
        ptr_nxt  = win;
        bcnt_nxt = run[3:0];
      end else begin
        ptr_nxt  = win + 2'd1;
        bcnt_nxt = 4'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bcnt <= 4'd0;
    else     bcnt <= bcnt_nxt;
  end
`else
  always_comb begin
    ptr_nxt = ptr;
    if (xfer) ptr_nxt = win + 2'd1;
  end
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (xfer) state_nxt = FULL;
      FULL:    if (out_ready && !xfer) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      ptr      <= 2'd0;
      out_data <= '0;
      out_id   <= 2'd0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      if (xfer) begin
        out_data <= sel_data;
        out_id   <= win;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter_4.sv
// tb/tb_rr_mux_arbiter_4.sv - directed and randomized checks of rr_mux_arbiter_4 against a queue-free arbitration model
module tb_rr_mux_arbiter_4;
  localparam int W = 4;
`ifdef ARB_BURST_EN
  localparam int MB = 3;
`else
  localparam int MB = 4;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   in_valid;
  logic [W-1:0] d [4];
  logic [3:0]   in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   out_id;

  int checks   = 0;
  int failures = 0;

  // reference model state
  int         m_ptr, m_id, m_last, m_cnt;
  bit         m_valid;
  logic [3:0] m_data;
  logic [3:0] seen_ready;

  always #5 clk = ~clk;

  rr_mux_arbiter_4 #(.W(W), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_data0(d[0]), .in_data1(d[1]), .in_data2(d[2]), .in_data3(d[3]),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_id(out_id)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_winner(input int p, input logic [3:0] v);
    for (int k = 0; k < 4; k++)
      if (v[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  function automatic logic [3:0] m_ready();
    int w;
    w = m_winner(m_ptr, in_valid);
    if (rst || w < 0 || (m_valid && !out_ready)) return 4'b0000;
    return 4'(1 << w);
  endfunction

  task automatic m_reset();
    m_ptr = 0; m_id = 0; m_last = 0; m_cnt = 0; m_valid = 0; m_data = '0;
  endtask

  // Settle combinational outputs after input changes and check in_ready against the model.
  task automatic settle();
    #1;
    seen_ready = in_ready;
    check("in_ready", {28'b0, in_ready}, {28'b0, m_ready()});
  endtask

  // Advance one clock, apply the transfer rules to the model, then check the registered outputs.
  task automatic tick();
    int w;
    int run;
    bit xfer;
    w    = m_winner(m_ptr, in_valid);
    xfer = !rst && (w >= 0) && (!m_valid || out_ready);
    @(posedge clk);
    if (rst) m_reset();
    else if (xfer) begin
      m_data  = d[w];
      m_id    = w;
      m_valid = 1;
`ifdef ARB_BURST_EN
      run    = (w == m_last) ? m_cnt + 1 : 1;
      m_last = w;
      if (run < MB) begin m_ptr = w; m_cnt = run; end
      else begin m_ptr = (w + 1) % 4; m_cnt = 0; end
`else
      run   = 0;
      m_ptr = (w + 1) % 4;
`endif
    end else if (out_ready) m_valid = 0;
    #1;
    check("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    if (m_valid) begin
      check("out_data", {28'b0, out_data}, {28'b0, m_data});
      check("out_id", {30'b0, out_id}, 32'(m_id));
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 4'b0; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) d[i] = '0;
    m_reset();
    @(posedge clk); #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data", {28'b0, out_data}, 32'd0);
    check("rst_out_id", {30'b0, out_id}, 32'd0);
    check("rst_in_ready", {28'b0, in_ready}, 32'd0);
    rst = 1'b0;

`ifndef ARB_BURST_EN
    // single requester
    in_valid = 4'b0100; d[2] = 4'hA; out_ready = 1'b1;
    settle(); check("single_ready", {28'b0, in_ready}, 32'h4);
    tick();
    check("single_data", {28'b0, out_data}, 32'hA);
    check("single_id", {30'b0, out_id}, 32'd2);
    in_valid = 4'b0000; settle(); tick();
    in_valid = 4'b1111;
    for (int i = 0; i < 4; i++) d[i] = 4'(i + 1);
    settle(); check("after_single_grant", {28'b0, in_ready}, 32'h8);
    tick();

    // rotation, back-to-back
    for (int k = 0; k < 8; k++) begin
      settle(); tick();
      check("rot_valid", {31'b0, out_valid}, 32'd1);
      check("rot_id", {30'b0, out_id}, 32'(k % 4));
      check("rot_data", {28'b0, out_data}, 32'(k % 4 + 1));
    end

    // reset mid-stream with a held word
    rst = 1'b1; #1;
    check("midrst_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_ready", {28'b0, in_ready}, 32'd0);
    @(posedge clk); m_reset(); #1;
    rst = 1'b0; in_valid = 4'b0000;
    settle(); tick();
    check("midrst_data", {28'b0, out_data}, 32'd0);
    check("midrst_id", {30'b0, out_id}, 32'd0);
    in_valid = 4'b1111; settle();
    check("midrst_ptr0", {28'b0, in_ready}, 32'h1);
    in_valid = 4'b0000; settle(); tick();

    // backpressure
    in_valid = 4'b0010; d[1] = 4'h5; out_ready = 1'b0;
    settle(); tick();
    in_valid = 4'b1000; d[3] = 4'h7;
    for (int k = 0; k < 3; k++) begin
      settle(); check("bp_ready", {28'b0, in_ready}, 32'd0);
      tick();
      check("bp_data", {28'b0, out_data}, 32'h5);
      check("bp_id", {30'b0, out_id}, 32'd1);
    end
    out_ready = 1'b1;
    settle(); check("bp_release_ready", {28'b0, in_ready}, 32'h8);
    tick();
    check("bp_release_data", {28'b0, out_data}, 32'h7);
    check("bp_release_id", {30'b0, out_id}, 32'd3);

    // wrap-around 3 -> 0
    in_valid = 4'b0100; settle(); tick();
    in_valid = 4'b1001;
    settle(); check("wrap_g3", {28'b0, in_ready}, 32'h8); tick();
    settle(); check("wrap_g0", {28'b0, in_ready}, 32'h1); tick();
    in_valid = 4'b1111;
    settle(); check("wrap_ptr1", {28'b0, in_ready}, 32'h2); tick();
`else
    // burst of MAX_BURST=3 per requester
    in_valid = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) d[i] = 4'(i + 1);
    for (int k = 0; k < 13; k++) begin
      settle(); tick();
      check("burst_id", {30'b0, out_id}, 32'((k / 3) % 4));
    end
`endif

    // randomized traffic; requesters hold valid/data until transferred
    in_valid = 4'b0000; settle();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (!in_valid[i] || seen_ready[i]) begin
          in_valid[i] = ($urandom_range(0, 2) != 0);
          d[i] = 4'($urandom);
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      if (n == 200) rst = 1'b1;
      if (n == 202) rst = 1'b0;
      settle();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
